// File: rtl/pattern_seq_ctrl_pkg.sv
// pattern_seq_ctrl_pkg: shared state, phase and pattern constants for the pattern sequencer
package pattern_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;
  localparam logic [2:0] DEF_PATTERN = 3'b101;
endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// pattern_seq_ctrl_if: command and status bundle between command source and sequencer
interface pattern_seq_ctrl_if #(parameter int CNT_W = 8);
  logic start;
  logic stop;
  logic pause;
  logic [CNT_W-1:0] rep_count;
  logic out1;
  logic [1:0] phase;
  logic busy;
  logic done;
  logic [CNT_W-1:0] rep_left;
  modport master (output start, stop, pause, rep_count, input out1, phase, busy, done, rep_left);
  modport slave (input start, stop, pause, rep_count, output out1, phase, busy, done, rep_left);
endinterface

// File: rtl/pattern_phase_gen.sv
// pattern_phase_gen: phase register 1->2->3->1 with registered out1 lookup from PATTERN
module pattern_phase_gen
  import pattern_seq_ctrl_pkg::*;
#(
  parameter logic [2:0] PATTERN = DEF_PATTERN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic       adv_i,
  output logic [1:0] phase_o,
  output logic       out1_o
);
  localparam logic [3:0] LUT = {PATTERN, 1'b0};
  logic [1:0] phase_q, phase_d;
  logic out1_q, out1_d;
  always_comb begin
    phase_d = clr_i ? PH_IDLE : ld_i ? PH1 : !adv_i ? phase_q :
              phase_q == PH1 ? PH2 : phase_q == PH2 ? PH3 : PH1;
    out1_d = LUT[phase_d];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase_q <= PH_IDLE;
      out1_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      out1_q <= out1_d;
    end
  assign phase_o = phase_q;
  assign out1_o = out1_q;
endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: start/stop/pause control FSM and repetition counter around the phase generator
module pattern_seq_ctrl
  import pattern_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter logic [2:0] PATTERN = DEF_PATTERN
) (
  input logic clk,
  input logic reset,
  pattern_seq_ctrl_if.slave bus
);
  state_t state_q;
  logic [CNT_W-1:0] rep_left_q;
  logic done_q, ld, clr, adv, last;
  always_comb begin
    last = state_q == ST_RUN && !bus.stop && !bus.pause && bus.phase == PH3 && rep_left_q == CNT_W'(1);
    ld = state_q == ST_IDLE && bus.start && !bus.stop;
    adv = state_q == ST_RUN && !bus.stop && !bus.pause && !last;
    clr = bus.stop || last;
  end
  pattern_phase_gen #(.PATTERN(PATTERN)) u_gen (
    .clk(clk), .reset(reset), .clr_i(clr), .ld_i(ld), .adv_i(adv),
    .phase_o(bus.phase), .out1_o(bus.out1)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      rep_left_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (bus.stop) begin
        state_q <= ST_IDLE;
        rep_left_q <= '0;
      end else
        case (state_q)
          ST_IDLE: if (ld) begin
            state_q <= ST_RUN;
            rep_left_q <= bus.rep_count;
          end
          ST_RUN: if (bus.pause) state_q <= ST_HOLD;
          else if (last) begin
            state_q <= ST_DONE;
            rep_left_q <= '0;
          end else if (bus.phase == PH3 && rep_left_q != '0) rep_left_q <= rep_left_q - CNT_W'(1);
          ST_HOLD: if (!bus.pause) state_q <= ST_RUN;
          ST_DONE: state_q <= ST_IDLE;
        endcase
    end
  assign bus.busy = state_q == ST_RUN || state_q == ST_HOLD;
  assign bus.done = done_q;
  assign bus.rep_left = rep_left_q;
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl: randomized and directed checks against a step-position reference model
module tb_pattern_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pattern_seq_ctrl_if #(.CNT_W(8)) b ();
  pattern_seq_ctrl_if #(.CNT_W(8)) b2 ();
  pattern_seq_ctrl #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  pattern_seq_ctrl #(.CNT_W(8), .PATTERN(3'b011)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  always_comb begin
    b2.start = b.start;
    b2.stop = b.stop;
    b2.pause = b.pause;
    b2.rep_count = b.rep_count;
  end
  int vectors = 0;
  int miscompares = 0;
  // model: a run is a walk over step positions 0..3*reps-1 (unbounded mod 3 when reps = 0)
  bit m_run, m_hold, m_done;
  int m_pos, m_reps;
  task automatic model_clear();
    m_run = 0; m_hold = 0; m_done = 0; m_pos = 0; m_reps = 0;
  endtask
  task automatic model_edge();
    if (reset) model_clear();
    else if (m_done) m_done = 0;
    else if (!m_run) begin
      if (b.start && !b.stop) begin m_run = 1; m_pos = 0; m_reps = int'(b.rep_count); end
    end else if (b.stop) begin m_run = 0; m_hold = 0; end
    else if (m_hold) m_hold = b.pause;
    else if (b.pause) m_hold = 1;
    else if (m_reps != 0 && m_pos + 1 == 3 * m_reps) begin m_run = 0; m_done = 1; end
    else m_pos = (m_reps == 0) ? (m_pos + 1) % 3 : m_pos + 1;
  endtask
  function automatic logic [12:0] exp_v(logic [2:0] pat);
    int k;
    logic [1:0] ph;
    logic o;
    logic [7:0] rl;
    k = m_pos % 3;
    ph = m_run ? 2'(k + 1) : 2'd0;
    o = m_run && pat[k];
    rl = (m_run && m_reps != 0) ? 8'(m_reps - m_pos / 3) : 8'd0;
    return {ph, o, logic'(m_run), logic'(m_done), rl};
  endfunction
  function automatic logic [12:0] obs1();
    return {b.phase, b.out1, b.busy, b.done, b.rep_left};
  endfunction
  function automatic logic [12:0] obs2();
    return {b2.phase, b2.out1, b2.busy, b2.done, b2.rep_left};
  endfunction
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    b.start = 0; b.stop = 0; b.pause = 0; b.rep_count = 0;
    model_clear();
    #1;
    vectors++;
    if (obs1() !== 13'h0) begin miscompares++; $display("FAIL reset_init: got %h want %h", obs1(), 13'h0); end
    @(posedge clk); #1 reset = 0;
    b.rep_count = 3; b.start = 1;
    tick();
    b.start = 0;
    tick();
    vectors++;
    if (obs1() !== exp_v(3'b101) || b.phase !== 2'd2) begin miscompares++; $display("FAIL reset_pre: got %h want %h", obs1(), exp_v(3'b101)); end
    #2 reset = 1;
    model_clear();
    #1;
    vectors++;
    if (obs1() !== 13'h0) begin miscompares++; $display("FAIL reset_async: got %h want %h", obs1(), 13'h0); end
    tick();
    reset = 0;
    repeat (3) begin
      tick();
      vectors++;
      if (obs1() !== 13'h0) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs1(), 13'h0); end
    end
  endtask

  task automatic test_counted();
    int phs[6] = '{1, 2, 3, 1, 2, 3};
    int o[6] = '{1, 0, 1, 1, 0, 1};
    int r[6] = '{2, 2, 2, 1, 1, 1};
    b.rep_count = 2; b.start = 1;
    tick();
    b.start = 0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs1() !== exp_v(3'b101) || {b.phase, b.out1, b.rep_left} !== {2'(phs[i]), 1'(o[i]), 8'(r[i])}) begin
        miscompares++; $display("FAIL counted_step%0d: got %h want %h", i, obs1(), exp_v(3'b101));
      end
      tick();
    end
    vectors++;
    if ({b.done, b.busy, b.phase, b.out1} !== 5'b10000) begin miscompares++; $display("FAIL counted_done: got %b want 10000", {b.done, b.busy, b.phase, b.out1}); end
    tick();
    vectors++;
    if (obs1() !== 13'h0) begin miscompares++; $display("FAIL counted_after: got %h want %h", obs1(), 13'h0); end
  endtask

  task automatic test_pause();
    int act = 0;
    b.rep_count = 1; b.start = 1;
    tick();
    b.start = 0;
    for (int i = 0; i < 12 && (b.busy || i == 0); i++) begin
      vectors++;
      if (obs1() !== exp_v(3'b101)) begin miscompares++; $display("FAIL pause_step%0d: got %h want %h", i, obs1(), exp_v(3'b101)); end
      if (b.busy) act++;
      b.pause = (i >= 1 && i <= 3);
      if (i >= 2 && i <= 4 && {b.phase, b.out1} !== 3'b100) begin
        miscompares++; $display("FAIL pause_hold%0d: got %b want 100", i, {b.phase, b.out1});
      end
      tick();
    end
    b.pause = 0;
    vectors++;
    if (act !== 7 || b.done !== 1'b1) begin miscompares++; $display("FAIL pause_len: got %0d/%b want 7/1", act, b.done); end
    tick();
  endtask

  task automatic test_stop();
    b.rep_count = 0; b.start = 1;
    tick();
    b.start = 0;
    repeat (10) begin
      vectors++;
      if (obs1() !== exp_v(3'b101) || b.rep_left !== 8'd0) begin miscompares++; $display("FAIL stop_run: got %h want %h", obs1(), exp_v(3'b101)); end
      tick();
    end
    b.stop = 1;
    tick();
    b.stop = 0;
    vectors++;
    if (obs1() !== 13'h0) begin miscompares++; $display("FAIL stop_abort: got %h want %h", obs1(), 13'h0); end
    tick();
    vectors++;
    if (b.done !== 1'b0) begin miscompares++; $display("FAIL stop_nodone: got %b want 0", b.done); end
  endtask

  task automatic test_simul();
    int act = 1;
    b.start = 1; b.stop = 1; b.rep_count = 2;
    tick();
    b.stop = 0; b.start = 0;
    vectors++;
    if ({b.busy, b.phase} !== 3'b000) begin miscompares++; $display("FAIL simul_idle: got %b want 000", {b.busy, b.phase}); end
    b.start = 1;
    tick();
    b.rep_count = 5;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (obs1() !== exp_v(3'b101)) begin miscompares++; $display("FAIL simul_run%0d: got %h want %h", i, obs1(), exp_v(3'b101)); end
      if (b.busy) act++;
      if (b.done || !b.busy) break;
    end
    b.start = 0;
    vectors++;
    if (act !== 6 || b.done !== 1'b1) begin miscompares++; $display("FAIL simul_len: got %0d/%b want 6/1", act, b.done); end
    tick();
  endtask

  task automatic test_pattern();
    int o[3] = '{1, 1, 0};
    b.rep_count = 1; b.start = 1;
    tick();
    b.start = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs2() !== exp_v(3'b011) || b2.out1 !== 1'(o[i])) begin miscompares++; $display("FAIL pattern_step%0d: got %h want %h", i, obs2(), exp_v(3'b011)); end
      tick();
    end
    vectors++;
    if ({b2.done, b2.phase} !== 3'b100) begin miscompares++; $display("FAIL pattern_done: got %b want 100", {b2.done, b2.phase}); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      b.start = $urandom_range(0, 3) == 0;
      b.stop = $urandom_range(0, 24) == 0;
      b.pause = $urandom_range(0, 5) == 0;
      b.rep_count = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      tick();
      vectors++;
      if (obs1() !== exp_v(3'b101)) begin miscompares++; $display("FAIL random_a%0d: got %h want %h", i, obs1(), exp_v(3'b101)); end
      vectors++;
      if (obs2() !== exp_v(3'b011)) begin miscompares++; $display("FAIL random_b%0d: got %h want %h", i, obs2(), exp_v(3'b011)); end
    end
    b.start = 0; b.stop = 0; b.pause = 0;
  endtask

  initial begin
    test_reset();
    test_counted();
    test_pause();
    test_stop();
    test_simul();
    test_pattern();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
